tia_player_graphics_scan: RTL and testbench

TIA_PLAYER_GRAPHICS_SCAN -- requirements
Module: tia_player_graphics_scan

---
 rtl/tia_player_graphics_scan.sv | 132 +++++++++++++
 tb/tb_tia_player_graphics_scan.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tia_player_graphics_scan.sv
// Player graphics serializer: an IDLE/ARMED/SCAN sequencer walks a 3-bit index
// across the selected graphics byte, MSB-first or reflected.
module tia_player_graphics_scan (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_bar,
  input  logic       fstob,
  input  logic       count_bar,
  input  logic [7:0] grp_data,
  input  logic       grp_wr,
  input  logic       grp_other_wr,
  input  logic       vdel,
  input  logic       refl,
  output logic       pixel,
  output logic       scan_active,
  output logic       copy_first,
  output logic       scan_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    SCAN  = 2'd2
  } state_t;

  state_t     state_r;
  state_t     state_s;
  logic [2:0] idx_r;
  logic [2:0] idx_s;
  logic       copy_first_r;
  logic       copy_first_s;
  logic       scan_done_r;
  logic       scan_done_s;
  logic [7:0] grp_new_r;
  logic [7:0] grp_old_r;
  logic [7:0] src_s;
  logic [2:0] bit_sel_s;
  logic       pixel_s;

  // Next-state logic; a fresh start request overrides any advance or end-of-scan.
  always_comb begin
    state_s      = state_r;
    idx_s        = idx_r;
    copy_first_s = copy_first_r;
    scan_done_s  = 1'b0;
    if (!start_bar) begin
      state_s      = ARMED;
      idx_s        = 3'd0;
      copy_first_s = fstob;
    end else begin
      case (state_r)
        IDLE: begin
          state_s = IDLE;
        end
        ARMED: begin
          if (!count_bar) begin
            state_s = SCAN;
            idx_s   = 3'd0;
          end else begin
            state_s = ARMED;
          end
        end
        SCAN: begin
          if (!count_bar) begin
            if (idx_r == 3'd7) begin
              state_s      = IDLE;
              idx_s        = 3'd0;
              copy_first_s = 1'b0;
              scan_done_s  = 1'b1;
            end else begin
              idx_s = idx_r + 3'd1;
            end
          end else begin
            state_s = SCAN;
          end
        end
        default: begin
          state_s      = IDLE;
          idx_s        = 3'd0;
          copy_first_s = 1'b0;
        end
      endcase
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      idx_r        <= 3'd0;
      copy_first_r <= 1'b0;
      scan_done_r  <= 1'b0;
    end else begin
      state_r      <= state_s;
      idx_r        <= idx_s;
      copy_first_r <= copy_first_s;
      scan_done_r  <= scan_done_s;
    end
  end

  // Graphics registers; old takes the pre-edge new value when both strobes coincide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grp_new_r <= 8'h00;
      grp_old_r <= 8'h00;
    end else begin
      if (grp_other_wr) begin
        grp_old_r <= grp_new_r;
      end
      if (grp_wr) begin
        grp_new_r <= grp_data;
      end
    end
  end

  // Live (non-snapshotted) pixel select so vdel/refl/graphics writes show immediately.
  always_comb begin
    src_s     = vdel ? grp_old_r : grp_new_r;
    bit_sel_s = refl ? idx_r : (3'd7 - idx_r);
    if (state_r == SCAN) begin
      pixel_s = src_s[bit_sel_s];
    end else begin
      pixel_s = 1'b0;
    end
  end

  assign pixel       = pixel_s;
  assign scan_active = (state_r == SCAN);
  assign copy_first  = copy_first_r;
  assign scan_done   = scan_done_r;

endmodule

// File: tb/tb_tia_player_graphics_scan.sv
// Directed + randomized bench for tia_player_graphics_scan against a
// pixels-remaining reference model.
module tb_tia_player_graphics_scan;

  logic       clk;
  logic       reset;
  logic       start_bar;
  logic       fstob;
  logic       count_bar;
  logic [7:0] grp_data;
  logic       grp_wr;
  logic       grp_other_wr;
  logic       vdel;
  logic       refl;
  logic       pixel;
  logic       scan_active;
  logic       copy_first;
  logic       scan_done;

  int checks   = 0;
  int failures = 0;

  // Reference model: armed flag plus count of pixels still to be shown.
  logic [7:0] m_new;
  logic [7:0] m_old;
  bit         m_armed;
  int         m_left;
  logic       m_first;
  logic       m_done;

  tia_player_graphics_scan dut (
    .clk          (clk),
    .reset        (reset),
    .start_bar    (start_bar),
    .fstob        (fstob),
    .count_bar    (count_bar),
    .grp_data     (grp_data),
    .grp_wr       (grp_wr),
    .grp_other_wr (grp_other_wr),
    .vdel         (vdel),
    .refl         (refl),
    .pixel        (pixel),
    .scan_active  (scan_active),
    .copy_first   (copy_first),
    .scan_done    (scan_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    m_new   = 8'h00;
    m_old   = 8'h00;
    m_armed = 1'b0;
    m_left  = 0;
    m_first = 1'b0;
    m_done  = 1'b0;
  endfunction

  function automatic void model_step();
    logic done_n;
    done_n = 1'b0;
    if (!start_bar) begin
      m_armed = 1'b1;
      m_left  = 0;
      m_first = fstob;
    end else if (m_armed) begin
      if (!count_bar) begin
        m_armed = 1'b0;
        m_left  = 8;
      end
    end else if (m_left > 0) begin
      if (!count_bar) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          done_n  = 1'b1;
          m_first = 1'b0;
        end
      end
    end
    if (grp_other_wr) m_old = m_new;
    if (grp_wr) m_new = grp_data;
    m_done = done_n;
  endfunction

  function automatic logic exp_pix();
    logic [7:0] src;
    int pos;
    if (m_left == 0) return 1'b0;
    src = vdel ? m_old : m_new;
    pos = 8 - m_left;
    return refl ? src[pos] : src[7 - pos];
  endfunction

  task automatic cmp(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s got=%0b exp=%0b", tag, obs, exp);
    end
  endtask

  task automatic cmp_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    #1;
    cmp({tag, ".pixel"}, pixel, exp_pix());
    cmp({tag, ".scan_active"}, scan_active, (m_left != 0));
    cmp({tag, ".copy_first"}, copy_first, m_first);
    cmp({tag, ".scan_done"}, scan_done, m_done);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic write_new(input logic [7:0] d);
    grp_data = d;
    grp_wr   = 1'b1;
    tick();
    grp_wr = 1'b0;
    check_all("wr");
  endtask

  task automatic arm(input logic fs);
    start_bar = 1'b0;
    fstob     = fs;
    count_bar = 1'b1;
    tick();
    start_bar = 1'b1;
    check_all("arm");
    cmp("arm.copy_first", copy_first, fs);
  endtask

  task automatic scan8(input logic [7:0] pat, input string tag);
    start_bar = 1'b1;
    count_bar = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_all(tag);
      cmp({tag, ".seq"}, pixel, pat[7 - i]);
      cmp({tag, ".active"}, scan_active, 1'b1);
    end
    tick();
    check_all(tag);
    cmp({tag, ".done"}, scan_done, 1'b1);
    cmp({tag, ".idle"}, scan_active, 1'b0);
    count_bar = 1'b1;
    tick();
    check_all(tag);
    cmp({tag, ".done_clr"}, scan_done, 1'b0);
  endtask

  initial begin
    int n_scan;
    int n_done;
    reset        = 1'b0;
    start_bar    = 1'b1;
    fstob        = 1'b0;
    count_bar    = 1'b1;
    grp_data     = 8'h00;
    grp_wr       = 1'b0;
    grp_other_wr = 1'b0;
    vdel         = 1'b0;
    refl         = 1'b0;
    model_reset();

    // Reset state, with a start request held during reset.
    #1 reset = 1'b1;
    start_bar = 1'b0;
    #2;
    check_all("reset");
    #3;
    reset     = 1'b0;
    start_bar = 1'b1;
    tick();
    check_all("post_reset");

    // Normal 0xA5 scan.
    write_new(8'hA5);
    arm(1'b1);
    scan8(8'b10100101, "a5_norm");

    // Reflected 0x03 after 0x81.
    refl = 1'b1;
    write_new(8'h81);
    write_new(8'h03);
    arm(1'b0);
    scan8(8'b11000000, "03_refl");

    // Double-width scan: count_bar low every other cycle.
    refl = 1'b0;
    write_new(8'hA5);
    arm(1'b0);
    n_scan = 0;
    n_done = 0;
    count_bar = 1'b0;
    for (int k = 0; k < 20; k++) begin
      logic [7:0] pat;
      pat = 8'hA5;
      tick();
      count_bar = (k % 2 == 0) ? 1'b1 : 1'b0;
      check_all("dbl");
      if (k < 16) cmp("dbl.seq", pixel, pat[7 - k / 2]);
      if (scan_active) n_scan++;
      if (scan_done) n_done++;
    end
    cmp_int("dbl.scan_cycles", n_scan, 16);
    cmp_int("dbl.done_count", n_done, 1);
    count_bar = 1'b1;

    // Vertical delay: simultaneous strobes.
    write_new(8'hF0);
    grp_data     = 8'h0F;
    grp_wr       = 1'b1;
    grp_other_wr = 1'b1;
    tick();
    grp_wr       = 1'b0;
    grp_other_wr = 1'b0;
    check_all("vdel_wr");
    vdel = 1'b1;
    arm(1'b1);
    scan8(8'b11110000, "vdel_old");
    vdel = 1'b0;
    arm(1'b0);
    scan8(8'b00001111, "vdel_new");

    // Restart at idx 4.
    write_new(8'h96);
    arm(1'b0);
    count_bar = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_all("pre_abort");
    end
    start_bar = 1'b0;
    fstob     = 1'b1;
    tick();
    start_bar = 1'b1;
    count_bar = 1'b1;
    check_all("abort");
    cmp("abort.done", scan_done, 1'b0);
    cmp("abort.active", scan_active, 1'b0);
    cmp("abort.copy_first", copy_first, 1'b1);
    tick();
    check_all("abort_hold");
    cmp("abort_hold.done", scan_done, 1'b0);
    scan8(8'b10010110, "restart");

    // Asynchronous reset at idx 5.
    write_new(8'hFF);
    arm(1'b1);
    count_bar = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_all("pre_rst");
    end
    cmp("pre_rst.pixel", pixel, 1'b1);
    #1;
    reset = 1'b1;
    model_reset();
    check_all("async_rst");
    cmp("async_rst.pixel", pixel, 1'b0);
    cmp("async_rst.active", scan_active, 1'b0);
    #2;
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_all("post_rst");
      cmp("post_rst.done", scan_done, 1'b0);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      tick();
      start_bar    = ($urandom_range(0, 29) != 0);
      fstob        = 1'($urandom_range(0, 1));
      count_bar    = 1'($urandom_range(0, 1));
      grp_wr       = ($urandom_range(0, 5) == 0);
      grp_other_wr = ($urandom_range(0, 7) == 0);
      grp_data     = 8'($urandom);
      if ($urandom_range(0, 15) == 0) vdel = ~vdel;
      if ($urandom_range(0, 15) == 0) refl = ~refl;
      check_all("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
